// File: rtl/event_palette_compositor.sv
// Event flash tracker and RGB222 colour stage: per-channel edge detect, frame-counted hold,
// fixed-priority background select. Optional frame blink under EVENT_PALETTE_BLINK_EN.
module event_palette_compositor #(
  parameter int          NUM_EVENTS  = 4,
  parameter int          HOLD_FRAMES = 8,
  parameter int          HOLD_W      = 8,
  parameter logic [5:0]  IDLE_BG     = 6'b000000
`ifdef EVENT_PALETTE_BLINK_EN
  , parameter int        BLINK_FRAMES = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_end,
  input  logic                    video_active,
  input  logic                    pixel_value,
  input  logic [5:0]              fg_colour,
  input  logic [NUM_EVENTS-1:0]   event_in,
  input  logic [6*NUM_EVENTS-1:0] event_bg,
  output logic [1:0]              R,
  output logic [1:0]              G,
  output logic [1:0]              B,
  output logic [NUM_EVENTS-1:0]   active_mask,
  output logic [NUM_EVENTS-1:0]   event_start
);

  logic [NUM_EVENTS-1:0] prev_q;
  logic [NUM_EVENTS-1:0] event_start_q;
  logic [HOLD_W-1:0]     cnt_q [NUM_EVENTS];
  logic [5:0]            rgb_q;
  logic [5:0]            rgb_d;
  logic [5:0]            bg_sel;
  logic [5:0]            bg_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= '0;
      event_start_q <= '0;
    end else begin
      prev_q        <= event_in;
      event_start_q <= event_in & ~prev_q;
    end
  end

  for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_chan
    // A live input reloads the hold, so reload takes precedence over the frame decrement.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[gi] <= '0;
      end else if (event_in[gi]) begin
        cnt_q[gi] <= HOLD_W'(HOLD_FRAMES);
      end else if (frame_end && (cnt_q[gi] != '0)) begin
        cnt_q[gi] <= cnt_q[gi] - HOLD_W'(1);
      end
    end

    assign active_mask[gi] = ~reset & ((cnt_q[gi] != '0) | event_in[gi]);
  end

  // Ascending scan: the highest active index overwrites lower ones.
  always_comb begin
    bg_sel = IDLE_BG;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (active_mask[i]) bg_sel = event_bg[6*i +: 6];
    end
  end

`ifdef EVENT_PALETTE_BLINK_EN
  localparam int PH_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [PH_W-1:0] phase_q;
  logic            blink_q;

  // Phase restarts whenever nothing is flashing, so each flash opens visible.
  always_ff @(posedge clk) begin
    if (reset || (active_mask == '0)) begin
      phase_q <= '0;
      blink_q <= 1'b0;
    end else if (frame_end) begin
      if (phase_q == PH_W'(BLINK_FRAMES - 1)) begin
        phase_q <= '0;
        blink_q <= ~blink_q;
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  assign bg_eff = blink_q ? IDLE_BG : bg_sel;
`else
  assign bg_eff = bg_sel;
`endif

  always_comb begin
    rgb_d = bg_eff;
    if (!video_active)   rgb_d = 6'b000000;
    else if (pixel_value) rgb_d = fg_colour;
  end

  always_ff @(posedge clk) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign R           = rgb_q[5:4];
  assign G           = rgb_q[3:2];
  assign B           = rgb_q[1:0];
  assign event_start = event_start_q;

endmodule
